mul_div_unit: RTL

- Iterative multiply/divide unit for the pipelined CPU. It owns the architectural HI/LO registers.
- The execute stage issues MULT/MULTU/DIV/DIVU to it. The stage stalls while busy is high.
- Write-back reads hi/lo for MFHI/MFLO and drives the MTHI/MTLO writes.
- Removes the combinational * and % from the write-back stage.

---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared CPU package: MDU op codes, control state encoding and the conditional
// negate helper used for operand magnitudes and result sign fix-up.
package mul_div_unit_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_DW    = 2 * MDU_WIDTH;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } mdu_state_e;

  typedef logic [MDU_DW-1:0] mdu_dword_t;

  // Two's-complement negate when neg is set; narrower callers zero-extend and
  // truncate, which leaves the low bits correct modulo their own width.
  function automatic mdu_dword_t cond_neg(input mdu_dword_t x, input logic neg);
    return neg ? (~x + mdu_dword_t'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute/write-back side of the multiply/divide unit: issue, MTHI/MTLO and HI/LO.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, flush, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, flush, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
// One iteration per cycle on operand magnitudes; signs are applied on completion.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, div_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next, quo_next;
  mdu_dword_t         prod_fix, quo_fix, rem_fix;
  logic               unused_bits;

  assign signed_op = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign div_op    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
  assign sa        = signed_op & bus.a[WIDTH-1];
  assign sb        = signed_op & bus.b[WIDTH-1];
  assign mag_a     = WIDTH'(cond_neg(mdu_dword_t'(bus.a), sa));
  assign mag_b     = WIDTH'(cond_neg(mdu_dword_t'(bus.b), sb));

  // Multiply: multiplier sits in the low half and shifts out LSB-first.
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: dividend shifts out of quo MSB-first while quotient bits shift in.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  assign div_ge    = div_shift >= {1'b0, dvsr_q};
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], div_ge};

  assign prod_fix = cond_neg(mdu_dword_t'(mul_next), qsign_q);
  assign quo_fix  = cond_neg(mdu_dword_t'(quo_next), qsign_q);
  assign rem_fix  = cond_neg(mdu_dword_t'(rem_next), rsign_q);

  assign unused_bits = ^{div_diff[WIDTH], quo_fix[MDU_DW-1:WIDTH], rem_fix[MDU_DW-1:WIDTH]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mcand_d  = mcand_q;
    dvsr_d   = dvsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (div_op && (bus.b == '0)) begin
            hi_d   = bus.a;
            lo_d   = '1;
            done_d = 1'b1;
          end else begin
            state_d  = ST_CALC;
            cnt_d    = '0;
            is_div_d = div_op;
            qsign_d  = sa ^ sb;
            rsign_d  = sa;
            mcand_d  = mag_a;
            dvsr_d   = mag_b;
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            rem_d    = '0;
            quo_d    = mag_a;
          end
        end else if (!bus.start) begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = mul_next;
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = rem_fix[WIDTH-1:0];
              lo_d = quo_fix[WIDTH-1:0];
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mcand_q  <= '0;
      dvsr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mcand_q  <= mcand_d;
      dvsr_q   <= dvsr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == ST_CALC);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
